// File: rtl/surf_splitter.sv
// Splits the 32-bit TURF-to-SURF stream into eight byte lanes: two beats form
// one 64-bit word, each byte is presented on its own lane with per-lane handshake.
module surf_splitter #(
  parameter bit    TIO_LANE_EN = 1'b1,
  parameter string DEBUG       = "TRUE"
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s_ev_tdata,
  input  logic        s_ev_tvalid,
  output logic        s_ev_tready,
  input  logic        s_ev_tlast,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tvalid,
  input  logic [7:0]  m_axis_tready,
  output logic [7:0]  m_axis_tlast,
  output logic        frame_err_o,
  output logic [15:0] err_count_o
);

  localparam int unsigned LANES  = 8;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = LANES * BYTE_W;
  localparam int unsigned CNT_W  = 16;

  // Lane 7 only participates in the drain when the TURFIO-local lane is enabled.
  localparam logic [LANES-1:0] LANE_MASK = {TIO_LANE_EN, 7'h7F};

  typedef enum logic [1:0] {
    ST_LOW   = 2'd0,
    ST_HIGH  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LANES-1:0]    r_pending;
  logic [LANES-1:0]    w_pending_nxt;
  logic                r_ready;
  logic [WORD_W-1:0]   r_data;
  logic                r_last;
  logic                r_frame_err;
  logic [CNT_W-1:0]    r_err_cnt;

  logic                w_in_hs;
  logic [LANES-1:0]    w_lane_hs;
  logic                w_load_lo;
  logic                w_load_hi;
  logic                w_odd_end;

  assign w_in_hs   = s_ev_tvalid & r_ready;
  assign w_lane_hs = r_pending & m_axis_tready;

  // Next-state, pending-lane and load-strobe decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_load_lo     = 1'b0;
    w_load_hi     = 1'b0;
    w_odd_end     = 1'b0;
    case (r_state)
      ST_LOW: begin
        if (w_in_hs) begin
          w_load_lo = 1'b1;
          if (s_ev_tlast) begin
            w_odd_end     = 1'b1;
            w_pending_nxt = LANE_MASK;
            w_state_nxt   = ST_DRAIN;
          end else begin
            w_state_nxt   = ST_HIGH;
          end
        end
      end
      ST_HIGH: begin
        if (w_in_hs) begin
          w_load_hi     = 1'b1;
          w_pending_nxt = LANE_MASK;
          w_state_nxt   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_pending_nxt = r_pending & ~w_lane_hs;
        if (w_pending_nxt == '0) begin
          w_state_nxt = ST_LOW;
        end
      end
      default: begin
        w_pending_nxt = '0;
        w_state_nxt   = ST_LOW;
      end
    endcase
  end

  // Control state; input ready is registered from the next state.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state   <= ST_LOW;
      r_pending <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_ready   <= (w_state_nxt != ST_DRAIN);
    end
  end

  // Word assembly; an odd-length frame pads the upper half with zeros.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_data <= '0;
      r_last <= 1'b0;
    end else begin
      if (w_load_lo) begin
        r_data[31:0] <= s_ev_tdata;
      end
      if (w_odd_end) begin
        r_data[63:32] <= '0;
        r_last        <= 1'b1;
      end
      if (w_load_hi) begin
        r_data[55:32] <= s_ev_tdata[23:0];
        r_data[63:56] <= TIO_LANE_EN ? s_ev_tdata[31:24] : 8'h00;
        r_last        <= s_ev_tlast;
      end
    end
  end

  // Framing error pulse and saturating error counter.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_frame_err <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_frame_err <= w_odd_end;
      if (w_odd_end && !(&r_err_cnt)) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  // Probe attachment point; the event ILA core is bound here at integration.
  if (DEBUG == "TRUE") begin : g_debug
  end

  assign s_ev_tready   = r_ready;
  assign m_axis_tdata  = r_data;
  assign m_axis_tvalid = r_pending;
  assign m_axis_tlast  = {LANES{r_last}};
  assign frame_err_o   = r_frame_err;
  assign err_count_o   = r_err_cnt;

endmodule
